// File: rtl/prbs_edge_shaper.sv
// PRBS bit stream to DAC code shaper: programmable high/low levels with a linear
// slew of ramp_step codes per dac_clk between them.
module prbs_edge_shaper #(
  parameter int unsigned DAC_W = 14
) (
  input  logic             dac_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             prbs_bit_in,
  input  logic             new_bit_valid,
  input  logic [DAC_W-1:0] level_high,
  input  logic [DAC_W-1:0] level_low,
  input  logic [DAC_W-1:0] ramp_step,
  input  logic             err_clr,
  output logic [DAC_W-1:0] dac_code,
  output logic             bit_out,
  output logic             edge_busy,
  output logic             edge_start,
  output logic             trunc_err
);

  typedef enum logic [1:0] {StIdle, StSettled, StSlewing} state_e;

  state_e           state_q, state_d;
  logic [DAC_W-1:0] dac_q, dac_d;
  logic             bit_q, bit_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic [DAC_W-1:0] hi_q, hi_d, lo_q, lo_d, step_q, step_d;

  logic             flip;
  logic             tgt_bit;
  logic [DAC_W-1:0] tgt;
  logic             up;
  logic [DAC_W:0]   diff;
  logic [DAC_W-1:0] stepped;
  logic             reach;

  // Target already reflects a bit flip arriving this cycle so a reversal steps from
  // the current code toward the new level without a jump.
  assign flip    = new_bit_valid && (prbs_bit_in != bit_q);
  assign tgt_bit = flip ? prbs_bit_in : bit_q;
  assign tgt     = tgt_bit ? hi_q : lo_q;
  assign up      = tgt > dac_q;
  assign diff    = up ? ({1'b0, tgt} - {1'b0, dac_q}) : ({1'b0, dac_q} - {1'b0, tgt});
  assign stepped = up ? (dac_q + step_q) : (dac_q - step_q);
  assign reach   = (step_q == '0) || (diff <= {1'b0, step_q});

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    bit_d   = bit_q;
    start_d = 1'b0;
    err_d   = err_q & ~err_clr;
    hi_d    = hi_q;
    lo_d    = lo_q;
    step_d  = step_q;

    if (state_q == StIdle) begin
      hi_d   = level_high;
      lo_d   = level_low;
      step_d = ramp_step;
    end

    if (!enable) begin
      state_d = StIdle;
      dac_d   = lo_d;
      bit_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSettled;
          dac_d   = lo_d;
          bit_d   = 1'b0;
        end
        StSettled: begin
          if (flip) begin
            bit_d   = prbs_bit_in;
            start_d = 1'b1;
            if (reach) begin
              dac_d = tgt;
            end else begin
              dac_d   = stepped;
              state_d = StSlewing;
            end
          end
        end
        StSlewing: begin
          if (flip) begin
            bit_d   = prbs_bit_in;
            start_d = 1'b1;
            err_d   = 1'b1;
          end
          if (reach) begin
            dac_d   = tgt;
            state_d = StSettled;
          end else begin
            dac_d = stepped;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      dac_q   <= '0;
      bit_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      bit_q   <= bit_d;
      start_q <= start_d;
      err_q   <= err_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      step_q  <= step_d;
    end
  end

  assign dac_code   = dac_q;
  assign bit_out    = bit_q;
  assign edge_busy  = (state_q == StSlewing);
  assign edge_start = start_q;
  assign trunc_err  = err_q;

endmodule

// File: tb/tb_prbs_edge_shaper.sv
// Bench for prbs_edge_shaper: directed vector table, hand-written corner sequences,
// then randomized traffic against a per-cycle behavioural model.
module tb_prbs_edge_shaper;

  logic        dac_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, prbs_bit_in = 1'b0, new_bit_valid = 1'b0, err_clr = 1'b0;
  logic [13:0] level_high = '0, level_low = '0, ramp_step = '0;
  logic [13:0] dac_code;
  logic        bit_out, edge_busy, edge_start, trunc_err;

  int n_cmp = 0;
  int n_bad = 0;

  prbs_edge_shaper #(.DAC_W(14)) dut (
    .dac_clk      (dac_clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .prbs_bit_in  (prbs_bit_in),
    .new_bit_valid(new_bit_valid),
    .level_high   (level_high),
    .level_low    (level_low),
    .ramp_step    (ramp_step),
    .err_clr      (err_clr),
    .dac_code     (dac_code),
    .bit_out      (bit_out),
    .edge_busy    (edge_busy),
    .edge_start   (edge_start),
    .trunc_err    (trunc_err)
  );

  always #5 dac_clk = ~dac_clk;

  typedef struct {
    logic        en, nbv, pb, clr;
    logic [13:0] hi, lo, step;
    logic [13:0] code;
    logic        bo, busy, start, err;
  } vec_t;

  task automatic check(input string name, input logic [13:0] c, input logic bo,
                       input logic busy, input logic st, input logic er);
    n_cmp++;
    if ({dac_code, bit_out, edge_busy, edge_start, trunc_err} !== {c, bo, busy, st, er}) begin
      n_bad++;
      $display("FAIL %s: got code=%0d bit=%0b busy=%0b start=%0b err=%0b, want code=%0d bit=%0b busy=%0b start=%0b err=%0b",
               name, dac_code, bit_out, edge_busy, edge_start, trunc_err, c, bo, busy, st, er);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    enable = v.en; new_bit_valid = v.nbv; prbs_bit_in = v.pb; err_clr = v.clr;
    level_high = v.hi; level_low = v.lo; ramp_step = v.step;
    @(posedge dac_clk);
    #1;
    check(name, v.code, v.bo, v.busy, v.start, v.err);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0; new_bit_valid = 1'b0; err_clr = 1'b0;
    @(posedge dac_clk);
    #2 reset_n = 1'b1;
    @(posedge dac_clk);
    #1;
  endtask

  // Behavioural model state
  int m_hi, m_lo, m_step, m_code;
  bit m_run, m_bit, m_start, m_err;

  task automatic model_step();
    int t, d;
    bit flip;
    if (!m_run) begin
      m_hi = int'(level_high); m_lo = int'(level_low); m_step = int'(ramp_step);
    end
    if (err_clr) m_err = 1'b0;
    m_start = 1'b0;
    if (!enable) begin
      m_run = 1'b0; m_bit = 1'b0; m_code = m_lo;
    end else if (!m_run) begin
      m_run = 1'b1; m_bit = 1'b0; m_code = m_lo;
    end else begin
      flip = new_bit_valid && (prbs_bit_in != m_bit);
      if (flip) begin
        if (m_code != (m_bit ? m_hi : m_lo)) m_err = 1'b1;
        m_bit = prbs_bit_in;
        m_start = 1'b1;
      end
      t = m_bit ? m_hi : m_lo;
      d = t - m_code;
      if (m_step == 0 || d <= m_step && d >= -m_step) m_code = t;
      else m_code = m_code + ((d > 0) ? m_step : -m_step);
    end
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd0,     1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd0,     1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd4000,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd8000,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd4000,  1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd0,     1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd4000,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd8000,  1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd12000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd16000, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd16383, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 14'd16383, 14'd0, 14'd4000, 14'd16383, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd16383, 1'b1, 1'b0, 1'b0, 1'b0};

    #2;
    check("reset_state", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 13; i++) apply($sformatf("slew_tbl[%0d]", i), tbl[i]);

    // Instantaneous edges
    do_reset();
    apply("step0_idle",   '{1'b0, 1'b0, 1'b0, 1'b0, 14'd16000, 14'd100, 14'd0, 14'd100,   1'b0, 1'b0, 1'b0, 1'b0});
    apply("step0_en",     '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16000, 14'd100, 14'd0, 14'd100,   1'b0, 1'b0, 1'b0, 1'b0});
    apply("step0_rise",   '{1'b1, 1'b1, 1'b1, 1'b0, 14'd16000, 14'd100, 14'd0, 14'd16000, 1'b1, 1'b0, 1'b1, 1'b0});
    apply("step0_hold",   '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16000, 14'd100, 14'd0, 14'd16000, 1'b1, 1'b0, 1'b0, 1'b0});
    // Shadowed config: new level_high ignored until the block passes through idle
    apply("shadow_fall",  '{1'b1, 1'b1, 1'b0, 1'b0, 14'd9000,  14'd100, 14'd0, 14'd100,   1'b0, 1'b0, 1'b1, 1'b0});
    apply("shadow_old",   '{1'b1, 1'b1, 1'b1, 1'b0, 14'd9000,  14'd100, 14'd0, 14'd16000, 1'b1, 1'b0, 1'b1, 1'b0});
    apply("shadow_dis",   '{1'b0, 1'b0, 1'b0, 1'b0, 14'd9000,  14'd100, 14'd0, 14'd100,   1'b0, 1'b0, 1'b0, 1'b0});
    apply("shadow_en",    '{1'b1, 1'b0, 1'b0, 1'b0, 14'd9000,  14'd100, 14'd0, 14'd100,   1'b0, 1'b0, 1'b0, 1'b0});
    apply("shadow_new",   '{1'b1, 1'b1, 1'b1, 1'b0, 14'd9000,  14'd100, 14'd0, 14'd9000,  1'b1, 1'b0, 1'b1, 1'b0});

    // Inverted levels
    do_reset();
    apply("inv_idle",  '{1'b0, 1'b0, 1'b0, 1'b0, 14'd2000, 14'd12000, 14'd5000, 14'd12000, 1'b0, 1'b0, 1'b0, 1'b0});
    apply("inv_en",    '{1'b1, 1'b0, 1'b0, 1'b0, 14'd2000, 14'd12000, 14'd5000, 14'd12000, 1'b0, 1'b0, 1'b0, 1'b0});
    apply("inv_r1",    '{1'b1, 1'b1, 1'b1, 1'b0, 14'd2000, 14'd12000, 14'd5000, 14'd7000,  1'b1, 1'b1, 1'b1, 1'b0});
    apply("inv_r2",    '{1'b1, 1'b0, 1'b0, 1'b0, 14'd2000, 14'd12000, 14'd5000, 14'd2000,  1'b1, 1'b0, 1'b0, 1'b0});
    apply("inv_f1",    '{1'b1, 1'b1, 1'b0, 1'b0, 14'd2000, 14'd12000, 14'd5000, 14'd7000,  1'b0, 1'b1, 1'b1, 1'b0});
    apply("inv_f2",    '{1'b1, 1'b0, 1'b0, 1'b0, 14'd2000, 14'd12000, 14'd5000, 14'd12000, 1'b0, 1'b0, 1'b0, 1'b0});

    // Asynchronous reset in the middle of a reversed slew
    do_reset();
    apply("rst_idle",  '{1'b0, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd0,    1'b0, 1'b0, 1'b0, 1'b0});
    apply("rst_en",    '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd0,    1'b0, 1'b0, 1'b0, 1'b0});
    apply("rst_r1",    '{1'b1, 1'b1, 1'b1, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd4000, 1'b1, 1'b1, 1'b1, 1'b0});
    apply("rst_r2",    '{1'b1, 1'b0, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd8000, 1'b1, 1'b1, 1'b0, 1'b0});
    apply("rst_f1",    '{1'b1, 1'b1, 1'b0, 1'b0, 14'd16383, 14'd0, 14'd4000, 14'd4000, 1'b0, 1'b1, 1'b1, 1'b1});
    #2 reset_n = 1'b0;
    #1 check("rst_async", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0; new_bit_valid = 1'b0; level_low = 14'd500;
    #1 reset_n = 1'b1;
    @(posedge dac_clk);
    #1 check("rst_release_low", 14'd500, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model
    do_reset();
    m_run = 1'b0; m_bit = 1'b0; m_start = 1'b0; m_err = 1'b0;
    m_hi = 0; m_lo = 0; m_step = 0; m_code = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        level_high = 14'($urandom_range(0, 16383));
        level_low  = ($urandom_range(0, 9) == 0) ? level_high : 14'($urandom_range(0, 16383));
        case ($urandom_range(0, 2))
          0:       ramp_step = 14'd0;
          1:       ramp_step = 14'($urandom_range(1, 400));
          default: ramp_step = 14'($urandom_range(1000, 9000));
        endcase
      end
      enable        = ($urandom_range(0, 39) != 0);
      new_bit_valid = ($urandom_range(0, 2) == 0);
      prbs_bit_in   = 1'($urandom_range(0, 1));
      err_clr       = ($urandom_range(0, 19) == 0);
      model_step();
      @(posedge dac_clk);
      #1;
      check($sformatf("rand[%0d]", c), 14'(m_code), m_bit,
            m_run && (m_code != (m_bit ? m_hi : m_lo)), m_start, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
